hazard_stall_ctrl: RTL and testbench

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/hazard_stall_ctrl.sv | 150 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline hold/flush/bubble controller for memory, divide, branch and load-use hazards
// Optional STALL_COUNTER_EN macro enables the saturating PC-hold cycle counter on STALL_COUNT.
module hazard_stall_ctrl #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  ID_RS1,
    input  logic [4:0]  ID_RS2,
    input  logic        ID_USES_RS1,
    input  logic        ID_USES_RS2,
    input  logic [4:0]  EX_DEST_REG,
    input  logic        EX_MEM_READ,
    input  logic        EX_REG_WRITE_ENABLE,
    input  logic        EX_DIV_START,
    input  logic        MEM_REQ,
    input  logic        MEM_READY,
    input  logic        BRANCH_TAKEN,
    output logic        PC_HOLD,
    output logic        IF_ID_HOLD,
    output logic        ID_EX_HOLD,
    output logic        EX_MA_HOLD,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_BUBBLE,
    output logic        EX_MA_BUBBLE,
    output logic        MA_WB_BUBBLE,
    output logic [1:0]  STATE,
    output logic [31:0] STALL_COUNT
);
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        DIV_WAIT = 2'b01,
        MEM_WAIT = 2'b10
    } state_t;

    localparam logic [7:0] DIV_LOAD   = 8'(DIV_CYCLES - 1);
    localparam bit         DIV_STALLS = (DIV_CYCLES > 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       memstall, loaduse;

    assign memstall = MEM_REQ && !MEM_READY;
    assign loaduse  = EX_MEM_READ && EX_REG_WRITE_ENABLE && (EX_DEST_REG != 5'd0) &&
                      ((ID_USES_RS1 && (ID_RS1 == EX_DEST_REG)) ||
                       (ID_USES_RS2 && (ID_RS2 == EX_DEST_REG)));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are gated by RESET so an asserted reset silences them without waiting for an edge.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        PC_HOLD      = 1'b0;
        IF_ID_HOLD   = 1'b0;
        ID_EX_HOLD   = 1'b0;
        EX_MA_HOLD   = 1'b0;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_BUBBLE = 1'b0;
        EX_MA_BUBBLE = 1'b0;
        MA_WB_BUBBLE = 1'b0;
        if (!RESET) begin
            case (state_q)
                RUN: begin
                    if (memstall) begin
                        PC_HOLD      = 1'b1;
                        IF_ID_HOLD   = 1'b1;
                        ID_EX_HOLD   = 1'b1;
                        EX_MA_HOLD   = 1'b1;
                        MA_WB_BUBBLE = 1'b1;
                        state_d      = MEM_WAIT;
                    end else if (EX_DIV_START && DIV_STALLS) begin
                        PC_HOLD      = 1'b1;
                        IF_ID_HOLD   = 1'b1;
                        ID_EX_HOLD   = 1'b1;
                        EX_MA_BUBBLE = 1'b1;
                        cnt_d        = DIV_LOAD;
                        state_d      = DIV_WAIT;
                    end else if (BRANCH_TAKEN) begin
                        IF_ID_FLUSH  = 1'b1;
                        ID_EX_BUBBLE = 1'b1;
                    end else if (loaduse) begin
                        PC_HOLD      = 1'b1;
                        IF_ID_HOLD   = 1'b1;
                        ID_EX_BUBBLE = 1'b1;
                    end
                end
                DIV_WAIT: begin
                    // The count==1 cycle is the divide's final EX cycle, so it runs unstalled.
                    if (cnt_q > 8'd1) begin
                        PC_HOLD      = 1'b1;
                        IF_ID_HOLD   = 1'b1;
                        ID_EX_HOLD   = 1'b1;
                        EX_MA_BUBBLE = 1'b1;
                        cnt_d        = cnt_q - 8'd1;
                    end else begin
                        cnt_d   = 8'd0;
                        state_d = RUN;
                    end
                end
                MEM_WAIT: begin
                    if (!MEM_READY) begin
                        PC_HOLD      = 1'b1;
                        IF_ID_HOLD   = 1'b1;
                        ID_EX_HOLD   = 1'b1;
                        EX_MA_HOLD   = 1'b1;
                        MA_WB_BUBBLE = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign STATE = state_q;

`ifdef STALL_COUNTER_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (PC_HOLD && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign STALL_COUNT = stall_cnt_q;
`else
    assign STALL_COUNT = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;
    localparam logic [7:0] NONE = 8'b0000_0000;
    localparam logic [7:0] MEMS = 8'b1111_0001;
    localparam logic [7:0] DIVS = 8'b1110_0010;
    localparam logic [7:0] BR   = 8'b0000_1100;
    localparam logic [7:0] LU   = 8'b1100_0100;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [4:0]  ID_RS1, ID_RS2, EX_DEST_REG;
    logic        ID_USES_RS1, ID_USES_RS2, EX_MEM_READ, EX_REG_WRITE_ENABLE;
    logic        EX_DIV_START, MEM_REQ, MEM_READY, BRANCH_TAKEN;
    logic        PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MA_HOLD;
    logic        IF_ID_FLUSH, ID_EX_BUBBLE, EX_MA_BUBBLE, MA_WB_BUBBLE;
    logic [1:0]  STATE;
    logic [31:0] STALL_COUNT;
    logic        h1_pc, h1_ifid, h1_idex, h1_exma, f1_ifid, b1_idex, b1_exma, b1_mawb;
    logic [1:0]  st1;
    logic [31:0] sc1;

    hazard_stall_ctrl #(.DIV_CYCLES(32)) u_dut (
        .CLK(CLK), .RESET(RESET), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2), .EX_DEST_REG(EX_DEST_REG),
        .EX_MEM_READ(EX_MEM_READ), .EX_REG_WRITE_ENABLE(EX_REG_WRITE_ENABLE),
        .EX_DIV_START(EX_DIV_START), .MEM_REQ(MEM_REQ), .MEM_READY(MEM_READY),
        .BRANCH_TAKEN(BRANCH_TAKEN), .PC_HOLD(PC_HOLD), .IF_ID_HOLD(IF_ID_HOLD),
        .ID_EX_HOLD(ID_EX_HOLD), .EX_MA_HOLD(EX_MA_HOLD), .IF_ID_FLUSH(IF_ID_FLUSH),
        .ID_EX_BUBBLE(ID_EX_BUBBLE), .EX_MA_BUBBLE(EX_MA_BUBBLE), .MA_WB_BUBBLE(MA_WB_BUBBLE),
        .STATE(STATE), .STALL_COUNT(STALL_COUNT)
    );

    hazard_stall_ctrl #(.DIV_CYCLES(1)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2), .EX_DEST_REG(EX_DEST_REG),
        .EX_MEM_READ(EX_MEM_READ), .EX_REG_WRITE_ENABLE(EX_REG_WRITE_ENABLE),
        .EX_DIV_START(EX_DIV_START), .MEM_REQ(MEM_REQ), .MEM_READY(MEM_READY),
        .BRANCH_TAKEN(BRANCH_TAKEN), .PC_HOLD(h1_pc), .IF_ID_HOLD(h1_ifid),
        .ID_EX_HOLD(h1_idex), .EX_MA_HOLD(h1_exma), .IF_ID_FLUSH(f1_ifid),
        .ID_EX_BUBBLE(b1_idex), .EX_MA_BUBBLE(b1_exma), .MA_WB_BUBBLE(b1_mawb),
        .STATE(st1), .STALL_COUNT(sc1)
    );

    always #5 CLK = ~CLK;

    logic [9:0] obs, obs1;
    assign obs  = {STATE, PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MA_HOLD,
                   IF_ID_FLUSH, ID_EX_BUBBLE, EX_MA_BUBBLE, MA_WB_BUBBLE};
    assign obs1 = {st1, h1_pc, h1_ifid, h1_idex, h1_exma, f1_ifid, b1_idex, b1_exma, b1_mawb};

    typedef struct {
        logic [9:0]  v;
        logic [31:0] sc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] model_sc = 32'd0;
    int          total = 0;
    int          bad = 0;

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] dst, input logic mr, input logic we,
                          input logic dv, input logic mq, input logic rdy, input logic br);
        ID_RS1 = rs1; ID_RS2 = rs2; ID_USES_RS1 = u1; ID_USES_RS2 = u2;
        EX_DEST_REG = dst; EX_MEM_READ = mr; EX_REG_WRITE_ENABLE = we;
        EX_DIV_START = dv; MEM_REQ = mq; MEM_READY = rdy; BRANCH_TAKEN = br;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Expected STALL_COUNT is the number of earlier held cycles since reset.
    task automatic push_exp(input logic [1:0] st, input logic [7:0] ctl);
        sb.push_back('{v: {st, ctl}, sc: model_sc});
`ifdef STALL_COUNTER_EN
        if (ctl[7]) model_sc = model_sc + 32'd1;
`endif
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            RESET = (i < 2);
            if (i == 0) set_in(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            else if (i == 1) set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            else idle();
            model_sc = 32'd0;
            push_exp(2'b00, NONE);
            @(negedge CLK);
            e = sb.pop_front();
            total++;
            if (obs !== e.v || STALL_COUNT !== e.sc) begin
                bad++;
                $display("FAIL reset c%0d: got %b sc=%0d want %b sc=%0d", i, obs, STALL_COUNT, e.v, e.sc);
            end
            next_cycle();
        end
    endtask

    task automatic test_load_use();
        logic [7:0] x;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin set_in(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); x = LU; end
                1: begin idle(); x = NONE; end
                2: begin set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); x = NONE; end
                3: begin set_in(5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); x = NONE; end
                4: begin set_in(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); x = NONE; end
                5: begin set_in(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); x = LU; end
                default: begin set_in(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); x = NONE; end
            endcase
            push_exp(2'b00, x);
            @(negedge CLK);
            e = sb.pop_front();
            total++;
            if (obs !== e.v || STALL_COUNT !== e.sc) begin
                bad++;
                $display("FAIL load_use c%0d: got %b sc=%0d want %b sc=%0d", i, obs, STALL_COUNT, e.v, e.sc);
            end
            next_cycle();
        end
    endtask

    task automatic test_branch();
        logic [7:0] x;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); x = BR; end
                1: begin set_in(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); x = BR; end
                default: begin idle(); x = NONE; end
            endcase
            push_exp(2'b00, x);
            @(negedge CLK);
            e = sb.pop_front();
            total++;
            if (obs !== e.v || STALL_COUNT !== e.sc) begin
                bad++;
                $display("FAIL branch c%0d: got %b sc=%0d want %b sc=%0d", i, obs, STALL_COUNT, e.v, e.sc);
            end
            next_cycle();
        end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) set_in(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, (i == 2));
            else if (i == 4) set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            else idle();
            if (i == 0) push_exp(2'b00, MEMS);
            else if (i < 4) push_exp(2'b10, MEMS);
            else if (i == 4) push_exp(2'b10, NONE);
            else push_exp(2'b00, NONE);
            @(negedge CLK);
            e = sb.pop_front();
            total++;
            if (obs !== e.v || STALL_COUNT !== e.sc) begin
                bad++;
                $display("FAIL mem_wait c%0d: got %b sc=%0d want %b sc=%0d", i, obs, STALL_COUNT, e.v, e.sc);
            end
            next_cycle();
        end
    endtask

    task automatic test_divide();
        for (int i = 0; i < 33; i++) begin
            idle();
            EX_DIV_START = (i == 0) || (i == 7);
            if (i == 5) begin MEM_REQ = 1'b1; MEM_READY = 1'b0; end
            if (i == 6) BRANCH_TAKEN = 1'b1;
            if (i == 0) push_exp(2'b00, DIVS);
            else if (i <= 30) push_exp(2'b01, DIVS);
            else if (i == 31) push_exp(2'b01, NONE);
            else push_exp(2'b00, NONE);
            @(negedge CLK);
            e = sb.pop_front();
            total++;
            if (obs !== e.v || STALL_COUNT !== e.sc) begin
                bad++;
                $display("FAIL divide c%0d: got %b sc=%0d want %b sc=%0d", i, obs, STALL_COUNT, e.v, e.sc);
            end
            if (i < 2) begin
                total++;
                if (obs1 !== 10'b0) begin
                    bad++;
                    $display("FAIL div_cycles1 c%0d: got %b want %b", i, obs1, 10'b0);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 35; i++) begin
            idle();
            if (i == 0) begin MEM_REQ = 1'b1; EX_DIV_START = 1'b1; end
            if (i == 1) begin MEM_REQ = 1'b1; MEM_READY = 1'b1; EX_DIV_START = 1'b1; end
            if (i == 2) EX_DIV_START = 1'b1;
            if (i == 0) push_exp(2'b00, MEMS);
            else if (i == 1) push_exp(2'b10, NONE);
            else if (i == 2) push_exp(2'b00, DIVS);
            else if (i <= 32) push_exp(2'b01, DIVS);
            else if (i == 33) push_exp(2'b01, NONE);
            else push_exp(2'b00, NONE);
            @(negedge CLK);
            e = sb.pop_front();
            total++;
            if (obs !== e.v || STALL_COUNT !== e.sc) begin
                bad++;
                $display("FAIL priority c%0d: got %b sc=%0d want %b sc=%0d", i, obs, STALL_COUNT, e.v, e.sc);
            end
            next_cycle();
        end
    endtask

    // Reset lands mid-cycle while the divide counter reads 10.
    task automatic test_reset_in_div();
        for (int i = 0; i < 25; i++) begin
            idle();
            if (i == 0) EX_DIV_START = 1'b1;
            if (i == 22) begin
                RESET = 1'b1;
                set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
                model_sc = 32'd0;
            end
            if (i == 23) RESET = 1'b0;
            if (i == 0) push_exp(2'b00, DIVS);
            else if (i <= 21) push_exp(2'b01, DIVS);
            else push_exp(2'b00, NONE);
            @(negedge CLK);
            e = sb.pop_front();
            total++;
            if (obs !== e.v || STALL_COUNT !== e.sc) begin
                bad++;
                $display("FAIL reset_in_div c%0d: got %b sc=%0d want %b sc=%0d", i, obs, STALL_COUNT, e.v, e.sc);
            end
            next_cycle();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_divide();
        test_priority();
        test_reset_in_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
